// File: rtl/cv32e40p_fetch_queue.sv
// OBI instruction prefetcher: credit-limited requests, in-order response FIFO, branch flush with stale-response discard.
// Entry visible one cycle after rvalid; consumer stalls via fetch_ready_i, and the bus request stops when credit runs out.

module cv32e40p_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop_i & (count_q != '0);
   assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_incr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_incr(rd_ptr_q);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push & ~flush_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

   assert property (@(posedge clk) disable iff (!rst_n) !(push_i & ~flush_i & ~do_push));

endmodule

module cv32e40p_fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        fetch_valid_o,
   input  logic        fetch_ready_i,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_addr_o,
   output logic        fetch_err_o,
   output logic        busy_o
);

   localparam int unsigned FCW = $clog2(DEPTH + 1);
   localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned EW  = 65;

   typedef enum logic {IDLE, WAIT_GNT} state_e;

   state_e         state_q, state_d;
   logic [31:0]    na_q, na_d;
   logic [31:0]    pend_addr_q, pend_addr_d;
   logic           stale_q, stale_d;
   logic [OCW-1:0] discard_q, discard_d;
   logic [OCW-1:0] outstanding;
   logic [FCW-1:0] fifo_count;
   logic [31:0]    resp_addr;
   logic [EW-1:0]  head_dat;
   logic           credit;
   logic           gnt_fire;
   logic           rv_ok;
   logic           push;
   logic           pop;
   logic           fetch_valid;
   logic           unused_addr_lsb;

   assign unused_addr_lsb = ^branch_addr_i[1:0];

   // Discarded responses still hold credit until they return.
   assign credit = (int'(outstanding) < int'(MAX_OUTSTANDING)) &
                   ((int'(outstanding) + int'(fifo_count)) < int'(DEPTH));

   always_comb begin
      state_d      = state_q;
      pend_addr_d  = pend_addr_q;
      instr_req_o  = 1'b0;
      instr_addr_o = na_q;
      case (state_q)
         IDLE: begin
            instr_req_o = rst_n & req_i & ~branch_i & credit;
            if (instr_req_o & ~instr_gnt_i) begin
               state_d     = WAIT_GNT;
               pend_addr_d = na_q;
            end
         end
         WAIT_GNT: begin
            instr_req_o  = rst_n;
            instr_addr_o = pend_addr_q;
            if (instr_gnt_i) state_d = IDLE;
         end
      endcase
   end

   assign gnt_fire = instr_req_o & instr_gnt_i;
   assign rv_ok    = instr_rvalid_i & (outstanding != '0);
   assign push     = rv_ok & ~branch_i & (discard_q == '0);
   assign pop      = fetch_valid & fetch_ready_i & ~branch_i;

   // A branch retires every in-flight response, including one granted this very cycle.
   always_comb begin
      na_d      = na_q;
      stale_d   = stale_q;
      discard_d = discard_q;
      if (branch_i) begin
         na_d      = {branch_addr_i[31:2], 2'b00};
         stale_d   = (state_q == WAIT_GNT) & ~instr_gnt_i;
         discard_d = outstanding + OCW'(gnt_fire) - OCW'(rv_ok);
      end else begin
         if (gnt_fire & ~stale_q) na_d = na_q + 32'd4;
         if (gnt_fire) stale_d = 1'b0;
         discard_d = discard_q + OCW'(gnt_fire & stale_q) - OCW'(rv_ok & (discard_q != '0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         na_q        <= '0;
         pend_addr_q <= '0;
         stale_q     <= 1'b0;
         discard_q   <= '0;
      end else begin
         state_q     <= state_d;
         na_q        <= na_d;
         pend_addr_q <= pend_addr_d;
         stale_q     <= stale_d;
         discard_q   <= discard_d;
      end
   end

   cv32e40p_fetch_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (32)
   ) u_addr_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (1'b0),
      .push_i     (gnt_fire),
      .push_dat_i (instr_addr_o),
      .pop_i      (rv_ok),
      .head_dat_o (resp_addr),
      .count_o    (outstanding)
   );

   cv32e40p_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_data_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (branch_i),
      .push_i     (push),
      .push_dat_i ({instr_rdata_i, resp_addr, instr_err_i}),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .count_o    (fifo_count)
   );

   assign fetch_valid   = (fifo_count != '0);
   assign fetch_valid_o = fetch_valid;
   assign fetch_rdata_o = fetch_valid ? head_dat[64:33] : '0;
   assign fetch_addr_o  = fetch_valid ? head_dat[32:1]  : '0;
   assign fetch_err_o   = fetch_valid & head_dat[0];
   assign busy_o        = (outstanding != '0) | instr_req_o;

   assert property (@(posedge clk) disable iff (!rst_n) instr_rvalid_i |-> (outstanding != '0));
   assert property (@(posedge clk) disable iff (!rst_n)
                    (instr_req_o & ~instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// Randomized bench for cv32e40p_fetch_queue with a transaction-level reference model.
module tb_cv32e40p_fetch_queue;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_addr_i = '0;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_err_i = 1'b0;
   logic        fetch_valid_o;
   logic        fetch_ready_i = 1'b0;
   logic [31:0] fetch_rdata_o;
   logic [31:0] fetch_addr_o;
   logic        fetch_err_o;
   logic        busy_o;

   cv32e40p_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .fetch_valid_o  (fetch_valid_o),
      .fetch_ready_i  (fetch_ready_i),
      .fetch_rdata_o  (fetch_rdata_o),
      .fetch_addr_o   (fetch_addr_o),
      .fetch_err_o    (fetch_err_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] addr; logic stale;} txn_t;
   typedef struct {logic [31:0] data; logic [31:0] addr; logic err;} ent_t;

   // Reference model: granted transactions awaiting a response, and entries owed to the consumer.
   txn_t        infl[$];
   ent_t        expq[$];
   logic [31:0] na_m = '0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_addr = '0;
   logic        hold_stale = 1'b0;

   logic [31:0] br_target = '0;
   logic        br_random = 1'b0;
   int          p_err = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      infl.delete();
      expq.delete();
      na_m = '0;
      hold_v = 1'b0;
      hold_stale = 1'b0;
   endtask

   task automatic step(input int p_req, input int p_gnt, input int p_rv, input int p_rdy, input int p_br);
      logic exp_req;
      logic credit_m;
      txn_t t;
      ent_t e;
      @(posedge clk);
      #1;
      req_i          = ($urandom_range(99) < p_req);
      branch_i       = ($urandom_range(99) < p_br);
      branch_addr_i  = br_random ? $urandom : br_target;
      if (br_random && $urandom_range(3) == 0) branch_addr_i[31:4] = 28'hFFFFFFF;
      instr_gnt_i    = ($urandom_range(99) < p_gnt);
      instr_rvalid_i = (infl.size() != 0) && ($urandom_range(99) < p_rv);
      instr_rdata_i  = $urandom;
      instr_err_i    = ($urandom_range(99) < p_err);
      fetch_ready_i  = ($urandom_range(99) < p_rdy);
      #3;
      credit_m = (infl.size() < MAXO) && (infl.size() + expq.size() < DEPTH);
      exp_req  = hold_v ? 1'b1 : (req_i && !branch_i && credit_m);
      check_val("instr_req", 32'(instr_req_o), 32'(exp_req));
      if (exp_req) check_val("instr_addr", instr_addr_o, hold_v ? hold_addr : na_m);
      check_val("busy", 32'(busy_o), 32'((infl.size() != 0) || exp_req));
      check_val("fetch_valid", 32'(fetch_valid_o), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
         check_val("fetch_rdata", fetch_rdata_o, expq[0].data);
         check_val("fetch_addr", fetch_addr_o, expq[0].addr);
         check_val("fetch_err", 32'(fetch_err_o), 32'(expq[0].err));
      end
      // Effects of this cycle at the coming edge; branch outranks everything else.
      if (expq.size() != 0 && fetch_ready_i && !branch_i) void'(expq.pop_front());
      if (instr_rvalid_i) begin
         t = infl.pop_front();
         if (!t.stale && !branch_i) begin
            e.data = instr_rdata_i;
            e.addr = t.addr;
            e.err  = instr_err_i;
            expq.push_back(e);
         end
      end
      if (exp_req && instr_gnt_i) begin
         t.addr  = hold_v ? hold_addr : na_m;
         t.stale = (hold_v && hold_stale) || branch_i;
         if (!(hold_v && hold_stale)) na_m = na_m + 32'd4;
         infl.push_back(t);
         hold_v = 1'b0;
         hold_stale = 1'b0;
      end else if (exp_req && !hold_v) begin
         hold_v = 1'b1;
         hold_addr = na_m;
         hold_stale = 1'b0;
      end
      if (branch_i) begin
         expq.delete();
         foreach (infl[i]) infl[i].stale = 1'b1;
         if (hold_v) hold_stale = 1'b1;
         na_m = {branch_addr_i[31:2], 2'b00};
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_instr_req"}, 32'(instr_req_o), 32'd0);
      check_val({pfx, "_instr_addr"}, instr_addr_o, 32'd0);
      check_val({pfx, "_fetch_valid"}, 32'(fetch_valid_o), 32'd0);
      check_val({pfx, "_fetch_rdata"}, fetch_rdata_o, 32'd0);
      check_val({pfx, "_fetch_addr"}, fetch_addr_o, 32'd0);
      check_val({pfx, "_fetch_err"}, 32'(fetch_err_o), 32'd0);
      check_val({pfx, "_busy"}, 32'(busy_o), 32'd0);
   endtask

   task automatic branch_to(input logic [31:0] target, input int p_gnt, input int p_rv);
      br_target = target;
      step(100, p_gnt, p_rv, 100, 100);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      req_i = 1'b1;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      req_i = 1'b0;
      rst_n = 1'b1;

      // Streaming from 0x100
      branch_to(32'h100, 100, 100);
      repeat (40) step(100, 100, 100, 100, 0);

      // Backpressure then release
      repeat (15) step(100, 100, 100, 0, 0);
      repeat (15) step(100, 100, 100, 100, 0);

      // Branch with two outstanding responses
      branch_to(32'h600, 100, 100);
      repeat (3) step(100, 100, 0, 100, 0);
      branch_to(32'h2002, 100, 0);
      repeat (20) step(100, 100, 100, 100, 0);

      // Branch while a request waits for grant
      repeat (3) step(100, 0, 100, 100, 0);
      branch_to(32'h400, 0, 100);
      repeat (2) step(0, 0, 100, 100, 0);
      repeat (20) step(100, 100, 100, 100, 0);

      // Address wrap with bus errors
      p_err = 100;
      branch_to(32'hFFFF_FFFC, 100, 100);
      repeat (6) step(100, 100, 100, 100, 0);
      p_err = 20;
      repeat (10) step(100, 100, 100, 100, 0);

      // Reset in the middle of a burst
      branch_to(32'h300, 100, 0);
      guard = 0;
      while (infl.size() < 2 && guard < 20) begin
         step(100, 100, 0, 100, 0);
         guard++;
      end
      if (guard >= 20) check_val("rst_setup_timeout", 32'(infl.size()), 32'd2);
      @(posedge clk);
      #1;
      req_i = 1'b1;
      instr_gnt_i = 1'b1;
      instr_rvalid_i = 1'b0;
      branch_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      req_i = 1'b0;
      instr_gnt_i = 1'b0;
      rst_n = 1'b1;
      repeat (10) step(100, 100, 100, 100, 0);

      // Mixed random traffic
      br_random = 1'b1;
      for (int ph = 0; ph < 20; ph++) begin
         int pr, pg, pv, pd, pb;
         pr = $urandom_range(100, 40);
         pg = $urandom_range(100, 20);
         pv = $urandom_range(100, 20);
         pd = $urandom_range(100, 10);
         pb = $urandom_range(10, 0);
         repeat (100) step(pr, pg, pv, pd, pb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cv32e40p_fetch_queue.md
CV32E40P_FETCH_QUEUE -- requirements
Module: cv32e40p_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal range 2..8.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum granted-but-unanswered bus transactions; legal range 1..4.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_i, input, 1, enables fetching.
REQ-006 SHALL have port branch_i, input, 1, flush and redirect.
REQ-007 SHALL have port branch_addr_i, input, 32, redirect target; bits [1:0] are ignored.
REQ-008 SHALL have ports instr_req_o (output, 1) and instr_addr_o (output, 32), the OBI request and its word address.
REQ-009 SHALL have ports instr_gnt_i (input, 1), instr_rvalid_i (input, 1), instr_rdata_i (input, 32) and instr_err_i (input, 1), the OBI grant and response.
REQ-010 SHALL have ports fetch_valid_o (output, 1) and fetch_ready_i (input, 1), the consumer handshake.
REQ-011 SHALL have ports fetch_rdata_o (output, 32), fetch_addr_o (output, 32) and fetch_err_o (output, 1), the head entry's word, its address and its bus error.
REQ-012 SHALL have port busy_o, output, 1, high while any transaction is outstanding or a request is pending.

Function
REQ-013 SHALL keep a next-address register (NA); each grant SHALL advance NA by 4 (mod 2^32; wraps from 0xFFFFFFFC to 0).
REQ-014 SHALL implement an FSM with two states:
- IDLE: instr_req_o = req_i & ~branch_i & credit.
- WAIT_GNT: instr_req_o = 1.
REQ-015 SHALL define credit as (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < DEPTH).
REQ-016 SHALL change state as follows: IDLE to WAIT_GNT on request without grant; WAIT_GNT to IDLE on grant; IDLE with request and grant stays IDLE.
REQ-017 SHALL hold instr_addr_o and instr_req_o stable in WAIT_GNT until grant (OBI), including across branch_i and req_i deassertion.
REQ-018 SHALL, on branch_i:
- load NA with {branch_addr_i[31:2],2'b00};
- empty the FIFO;
- set discard count = outstanding responses not yet returned.
REQ-019 SHALL also, on branch_i in WAIT_GNT, keep the pending stale address and mark that transaction for discard when it is granted.
REQ-020 SHALL decrement the discard count on each rvalid and drop the response.
REQ-021 SHALL take branch_i over every simultaneous event: a same-cycle rvalid is discarded and a same-cycle pop has no effect.
REQ-022 SHALL write each non-discarded response into the FIFO as {rdata, address, err}, where address is the address at grant.
REQ-023 SHALL make a written entry visible the cycle after rvalid (no bypass), giving minimum latency grant -> rvalid -> fetch_valid_o of 1 cycle after rvalid.
REQ-024 SHALL assert fetch_valid_o iff the FIFO is non-empty, and SHALL drive fetch_rdata_o, fetch_addr_o and fetch_err_o from the head entry.
REQ-025 SHALL pop the head on fetch_valid_o & fetch_ready_i & ~branch_i.
REQ-026 SHALL accept a push and a pop in the same cycle when full.
REQ-027 SHALL never overflow, because credit guarantees every outstanding response a slot.
REQ-028 SHALL treat rvalid with zero outstanding as a protocol error: ignored, and flagged by an assertion.
REQ-029 SHALL store an error response like data with fetch_err_o = 1, and SHALL continue fetching.
REQ-030 SHALL, when req_i is low, issue no new request while outstanding responses still complete and fill the FIFO.

Reset
REQ-031 SHALL, while rst_n is low, immediately set: state IDLE, NA = 0, FIFO empty, outstanding = 0, discard = 0.
REQ-032 SHALL drive these outputs during reset: instr_req_o = 0, instr_addr_o = 0, fetch_valid_o = 0, fetch_rdata_o = 0, fetch_addr_o = 0, fetch_err_o = 0, busy_o = 0.
REQ-033 SHALL abandon all pending and outstanding transactions on reset mid-operation; responses arriving after release with zero outstanding follow REQ-028.

Verification
REQ-034 SHALL cover streaming: DEPTH=4, MAX_OUTSTANDING=2, branch to 0x100, gnt always high, rvalid 1 cycle after grant, fetch_ready_i=1 -> addresses 0x100, 0x104, 0x108... delivered one per cycle, never more than 2 outstanding.
REQ-035 SHALL cover backpressure: fetch_ready_i=0 -> exactly 4 entries held, instr_req_o drops; release -> in-order delivery 0x100..0x10C with no loss.
REQ-036 SHALL cover branch with two outstanding: branch to 0x2002 -> both stale responses dropped, first delivered entry has fetch_addr_o=0x2000.
REQ-037 SHALL cover branch in WAIT_GNT: gnt low for 3 cycles, then branch to 0x400 -> instr_addr_o unchanged until grant, that response dropped, next request address 0x400.
REQ-038 SHALL cover wrap and error: branch to 0xFFFFFFFC, respond with instr_err_i=1 -> entry 0xFFFFFFFC delivered with fetch_err_o=1, next request address 0x00000000.
REQ-039 SHALL cover reset mid-burst: assert rst_n low with 2 outstanding -> all outputs reach reset values in the same cycle.
